// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
// PWM_CAPTURE_DEGLITCH_EN (in pwm_edge_sync) selects the optional deglitch filter.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_cap_state_t;

    localparam int PWM_CNT_W_DEF    = 8;
    localparam int PWM_DEGLITCH_LEN = 3;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizer, optional deglitch filter (PWM_CAPTURE_DEGLITCH_EN) and edge detector.
// Edge strobes are registered; s is the level aligned with rise/fall.
module pwm_edge_sync
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_cur;
    logic                   s_d;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

`ifdef PWM_CAPTURE_DEGLITCH_EN
    // The window spans the live synchronizer output plus its last two values,
    // so a new level takes effect combinationally on its third consecutive cycle.
    logic [PWM_DEGLITCH_LEN-2:0] hist_q;
    logic [PWM_DEGLITCH_LEN-1:0] window;
    logic                        filt_q;

    assign window = {hist_q, sync_q[SYNC_STAGES-1]};

    always_comb begin
        s_cur = filt_q;
        if (&window) begin
            s_cur = 1'b1;
        end else if (~|window) begin
            s_cur = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[PWM_DEGLITCH_LEN-3:0], sync_q[SYNC_STAGES-1]};
            filt_q <= s_cur;
        end
    end
`else
    assign s_cur = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_d    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s_d    <= s_cur;
            rise_q <= s_cur & ~s_d;
            fall_q <= ~s_cur & s_d;
        end
    end

    assign s    = s_d;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period between rising edges and flags
// stuck / over-range inputs. Build with PWM_CAPTURE_DEGLITCH_EN for the filter.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_valid,
    output logic             overflow,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    logic             rise;
    logic             fall;
    logic             saturated;
    pwm_cap_state_t   state_q, state_nxt;
    logic [CNT_W-1:0] cnt_period_q, cnt_period_nxt;
    logic [CNT_W-1:0] cnt_high_q, cnt_high_nxt;
    logic [CNT_W-1:0] meas_high_nxt, meas_period_nxt;
    logic             valid_nxt, ovf_nxt, stuck_nxt, stuck_level_nxt;

    pwm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    assign saturated = (cnt_period_q == CNT_MAX) && !rise;

    // IDLE also times out after reset so a dead input is reported; once stuck it stops counting.
    always_comb begin
        state_nxt       = state_q;
        cnt_period_nxt  = cnt_period_q;
        cnt_high_nxt    = cnt_high_q;
        meas_high_nxt   = meas_high;
        meas_period_nxt = meas_period;
        valid_nxt       = 1'b0;
        ovf_nxt         = 1'b0;
        stuck_nxt       = stuck;
        stuck_level_nxt = stuck_level;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_nxt      = HIGH;
                    cnt_period_nxt = CNT_ONE;
                    cnt_high_nxt   = CNT_ONE;
                    stuck_nxt      = 1'b0;
                end else if (!stuck) begin
                    if (saturated) begin
                        ovf_nxt         = 1'b1;
                        stuck_nxt       = 1'b1;
                        stuck_level_nxt = s;
                    end else begin
                        cnt_period_nxt = cnt_period_q + 1'b1;
                    end
                end
            end
            HIGH: begin
                if (saturated) begin
                    state_nxt       = IDLE;
                    ovf_nxt         = 1'b1;
                    stuck_nxt       = 1'b1;
                    stuck_level_nxt = s;
                end else begin
                    cnt_period_nxt = cnt_period_q + 1'b1;
                    if (fall) begin
                        state_nxt = LOW;
                    end else begin
                        cnt_high_nxt = cnt_high_q + 1'b1;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt       = HIGH;
                    meas_period_nxt = cnt_period_q;
                    meas_high_nxt   = cnt_high_q;
                    valid_nxt       = 1'b1;
                    cnt_period_nxt  = CNT_ONE;
                    cnt_high_nxt    = CNT_ONE;
                end else if (saturated) begin
                    state_nxt       = IDLE;
                    ovf_nxt         = 1'b1;
                    stuck_nxt       = 1'b1;
                    stuck_level_nxt = s;
                end else begin
                    cnt_period_nxt = cnt_period_q + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_period_q <= '0;
            cnt_high_q   <= '0;
            meas_high    <= '0;
            meas_period  <= '0;
            meas_valid   <= 1'b0;
            overflow     <= 1'b0;
            stuck        <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_period_q <= cnt_period_nxt;
            cnt_high_q   <= cnt_high_nxt;
            meas_high    <= meas_high_nxt;
            meas_period  <= meas_period_nxt;
            meas_valid   <= valid_nxt;
            overflow     <= ovf_nxt;
            stuck        <= stuck_nxt;
            stuck_level  <= stuck_level_nxt;
        end
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM receiver/demodulator: samples an asynchronous PWM input, measures high time and period in clock cycles over each rising-to-rising edge interval, and publishes each completed measurement with a one-cycle valid strobe. It is the receiving end of our PWM generator and is used to loop back generator output, or to decode external PWM, on the same clock domain. Partial first periods, stuck inputs and over-range periods are detected and flagged, never reported as measurements.

## Interface
- `CNT_W`, default 8: width of the measurement counters; the longest measurable period is 2^CNT_W−1 cycles.
- `SYNC_STAGES`, default 2, minimum 2: number of synchronizer flops on `pwm_in`.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `pwm_in` input 1: asynchronous PWM input.
- `meas_high` output CNT_W: synchronized-high cycles in the last completed period.
- `meas_period` output CNT_W: cycles from one rising edge to the next, for the last completed period.
- `meas_valid` output 1: one-cycle strobe; `meas_high` and `meas_period` were updated this cycle.
- `overflow` output 1: one-cycle strobe; the period counter saturated before a closing rising edge.
- `stuck` output 1: level; no edge has been seen since the last overflow.
- `stuck_level` output 1: synchronized input level captured at overflow; meaningful only while `stuck`=1.

## Operation
- Input path: `pwm_in` → SYNC_STAGES flops → `s`. Register `s_d` holds the previous `s`. `rise` = `s & !s_d`. `fall` = `!s & s_d`.
- FSM states:
  - IDLE: the reset state. The first period is partial and is discarded.
    - On `rise` → HIGH, `cnt_period`=1, `cnt_high`=1.
  - HIGH: each cycle `cnt_period`++ and `cnt_high`++.
    - On `fall` → LOW; `cnt_period`++ only.
  - LOW: each cycle `cnt_period`++.
    - On `rise` → HIGH: register `meas_period`←`cnt_period`, `meas_high`←`cnt_high`, assert `meas_valid`, then restart both counters at 1.
- A rising edge cannot be detected while in HIGH.
- Saturation:
  - If `cnt_period` = 2^CNT_W−1 in HIGH or LOW and no `rise` occurs that cycle → next state IDLE.
  - That transition pulses `overflow`, sets `stuck`=1 and sets `stuck_level`=`s`.
  - `meas_*` keep their previous values.
- `stuck` clears on the next `rise`, which restarts measurement from IDLE.
- Arithmetic: counters are unsigned CNT_W bits and never wrap. Invariant: `meas_high` < `meas_period`.
- Simultaneous events: a `rise` on the saturation cycle counts as a valid closing edge; it produces no overflow.
- Reset: when `rst_n`=0 at a clock edge, every register returns to its reset value, including any measurement in progress. No partial measurement is published.

## Timing
- Reset values: `meas_high`=0, `meas_period`=0, `meas_valid`=0, `overflow`=0, `stuck`=0, `stuck_level`=0, FSM=IDLE. Synchronizer flops and `s_d` also reset to 0.
- Latency: `meas_valid` rises SYNC_STAGES+1 clock edges after the edge that first samples the closing high level of `pwm_in`. Add +2 with the deglitch filter compiled in.
- `meas_valid` and `overflow` are single-cycle strobes and are never both high in the same cycle.
- `meas_high` and `meas_period` are stable between `meas_valid` strobes.
- There is no backpressure. A consumer that misses a strobe loses that sample.

## Configuration
- Macro: `PWM_CAPTURE_DEGLITCH_EN`.
- Defined: a filter follows the synchronizer. `s` changes only after the synchronized input has held its new value for 3 consecutive cycles. Pulses of 1–2 cycles, high or low, are ignored. Latency increases by 2 cycles; measured widths of pulses that pass the filter are unchanged.
- Undefined: `s` is the last synchronizer stage. A 1-cycle pulse is measured as 1.

## Structure
- Package `pwm_pkg` holds:
  - the FSM state enum `pwm_cap_state_t` (IDLE, HIGH, LOW);
  - the default counter width constant `PWM_CNT_W_DEF`=8;
  - the deglitch length constant `PWM_DEGLITCH_LEN`=3.
- Sub-module `pwm_edge_sync` contains the synchronizer, the optional deglitch filter and the edge detector. It outputs `s`, `rise` and `fall`.
- `pwm_capture` contains the FSM, the counters and the output registers.

## Test plan
- Generator loopback, period 8, duty 3 → after the first discarded period, `meas_valid` every 8 cycles with `meas_high`=3, `meas_period`=8.
- Duty 0 (input held low) from reset → `overflow` pulses once, `stuck`=1, `stuck_level`=0. No `meas_valid`. A later 5-high/5-low waveform gives `stuck`=0, then `meas_high`=5, `meas_period`=10.
- Duty 100% (input held high after one rise), CNT_W=8 → `overflow` 255 cycles after the rise, `stuck_level`=1.
- Period exactly 255, high 100, CNT_W=8 → valid measurement with `meas_period`=255, `meas_high`=100, and no `overflow`.
- Assert `rst_n`=0 for 1 cycle mid-LOW → all outputs 0 on the next cycle. The next full period is measured correctly and the partial one is discarded.
- Inject a 1-cycle high glitch into a low phase → counted as an edge with `meas_high`=1 when `PWM_CAPTURE_DEGLITCH_EN` is undefined. Ignored, with `meas_*` unchanged, when it is defined.
